load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: sits between the CPU execute/memory stage and the byte-addressed, big-endian, word-ported synchronous data memory.
- Executes lb/lbu/lh/lhu/lw/sb/sh/sw. Sub-word loads are extracted and extended. Sub-word stores use read-modify-write, because the memory only performs full 4-byte accesses.
- One request is outstanding at a time; the CPU side uses a req/busy/done handshake.

Parameters:
ADDR_WIDTH, 11, byte-address width of data memory (2048 bytes)

Ports:
clock  input  1  single clock; all state on posedge
reset  input  1  asynchronous, active-high reset
req  input  1  CPU request strobe; accepted when busy=0
is_store  input  1  1=store, 0=load
size  input  2  00=byte, 01=halfword, 10=word, 11=reserved (treated as word)
is_unsigned  input  1  loads only: 1=zero-extend, 0=sign-extend
addr  input  ADDR_WIDTH  CPU byte address
store_data  input  32  store operand; byte/half taken from low bits
busy  output  1  request in flight
done  output  1  one-cycle completion pulse
error  output  1  one-cycle misalignment pulse, coincident with done
load_data  output  32  extended load result; valid when done=1, held until the next load completes
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
address  output  ADDR_WIDTH  memory byte address, always word-aligned (low 2 bits 0)
write_data  output  32  memory write word; bits [31:24] go to the byte at address
read_data  input  32  memory read word; registered by memory on the edge where MemRead=1

Behaviour:
- Reset (async, immediate): state=IDLE; busy, done, error, MemRead, MemWrite = 0; load_data, address, write_data = 0; any captured request is discarded. If reset is asserted before a WR-state edge, no memory write occurs.
- Acceptance: req=1 and busy=0 at a posedge (cycle 0) registers addr, size, is_store, is_unsigned and store_data. Inputs may change afterwards. req while busy=1 is ignored; there is no queue.
- MemRead, MemWrite, address and write_data are decoded from registered state only; there is no combinational path from req.
- FSM states: IDLE, RD, CAP, WR, FIN.
  - IDLE -> RD for a load or a sub-word store.
  - IDLE -> WR for a word store.
  - IDLE -> FIN for a misaligned request.
  - RD: MemRead=1, address = {addr[ADDR_WIDTH-1:2],2'b00}. Always -> CAP.
  - CAP: read_data is valid. For a load: extract the lane, extend, register load_data, -> FIN. For a sub-word store: merge the new lane into the read word, register write_data, -> WR.
  - WR: MemWrite=1 for exactly one cycle, same aligned address. -> FIN.
  - FIN: done=1 (error=1 if misaligned), busy=0, -> IDLE. A req may be accepted in FIN and is treated as if accepted in IDLE.
- busy=1 in RD, CAP and WR.
- Lane mapping (big-endian), k=addr[1:0]:
  - Byte k = read_data[31-8k -: 8].
  - Half at k=0 = [31:16]; half at k=2 = [15:0].
  - Sign source is the top bit of the lane.
- Latency, done cycle counted from acceptance at cycle 0:
  - Load: 3.
  - Word store: 2.
  - Sub-word store: 4.
  - Misaligned: 1.
- Misaligned requests are halfword with addr[0]=1, or word/reserved with addr[1:0]!=0. Handling is per Optional Feature.
- Never asserted together: MemRead and MemWrite.
- No address wrap: aligned address is at most 2^ADDR_WIDTH-4, so a 4-byte access stays in range.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: misaligned request makes no memory access; FIN follows immediately (done+error in cycle 1); load_data and memory are unchanged.
- Undefined: error tied 0. Low address bits are forced to alignment (half: addr[0]=0; word: addr[1:0]=0) and the access proceeds normally.

Test Plan:
Memory is preloaded with word 0x8899AABB at 0x010.
1. Load byte, signed, addr=0x012 -> MemRead in cycle 1 with address=0x010; done in cycle 3; load_data=0xFFFFFFAA.
2. Load half, unsigned, addr=0x012 -> load_data=0x0000AABB. Repeat with addr=0x010 signed -> 0xFFFF8899.
3. Store byte, store_data=0x0000005C, addr=0x011 -> RD in cycle 1, MemWrite in cycle 3 with write_data=0x885CAABB, done in cycle 4; memory word at 0x010 reads 0x885CAABB.
4. Store word 0x12345678 at addr=0x020 -> MemRead never asserted; MemWrite in cycle 1 with address=0x020; done in cycle 2. Back-to-back req in the FIN cycle is accepted.
5. Load word at addr=0x013:
   - With MISALIGN_TRAP_EN: done=error=1 in cycle 1, no MemRead.
   - Without: access at 0x010, load_data=0x8899AABB in cycle 3.
6. Store half at addr=0x010, reset asserted mid-cycle 2 (CAP) -> MemRead/MemWrite drop immediately; MemWrite never asserted; memory still 0x8899AABB; all outputs 0; next req after release completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bus interfaces for the load/store unit: CPU request side and word-ported data-memory side.
interface cpu_bus_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  req;
  logic                  is_store;
  logic [1:0]            size;
  logic                  is_unsigned;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           store_data;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [31:0]           load_data;

  modport master (output req, is_store, size, is_unsigned, addr, store_data,
                  input  busy, done, error, load_data);
  modport slave  (input  req, is_store, size, is_unsigned, addr, store_data,
                  output busy, done, error, load_data);
endinterface

interface mem_bus_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  MemRead;
  logic                  MemWrite;
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0]           write_data;
  logic [31:0]           read_data;

  modport master (output MemRead, MemWrite, address, write_data, input  read_data);
  modport slave  (input  MemRead, MemWrite, address, write_data, output read_data);
endinterface

// File: rtl/load_store_unit.sv
// Big-endian load/store initiator; sub-word stores go through read-modify-write.
// Define MISALIGN_TRAP_EN to trap misaligned requests instead of forcing alignment.
module load_store_unit #(
  parameter int ADDR_WIDTH = 11
) (
  input logic       clock,
  input logic       reset,
  cpu_bus_if.slave  cpu,
  mem_bus_if.master mem
);
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-3:0] waddr;
    logic [1:0]            off;
    logic [1:0]            size;
    logic                  is_store;
    logic                  is_unsigned;
    logic                  trap;
    logic [15:0]           sdata;
  } req_t;

  state_t      state, state_nxt;
  req_t        r_q, r_in;
  logic        accept;
  logic [1:0]  size_eff;
  logic [31:0] wdata_q, ldata_q, merged, extended;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign accept   = cpu.req && (state == IDLE || state == FIN);
  assign size_eff = (cpu.size == 2'b11) ? 2'b10 : cpu.size;

  always_comb begin
    r_in             = '0;
    r_in.waddr       = cpu.addr[ADDR_WIDTH-1:2];
    r_in.size        = size_eff;
    r_in.is_store    = cpu.is_store;
    r_in.is_unsigned = cpu.is_unsigned;
    r_in.sdata       = cpu.store_data[15:0];
`ifdef MISALIGN_TRAP_EN
    r_in.off  = cpu.addr[1:0];
    r_in.trap = (size_eff == 2'b01 && cpu.addr[0]) ||
                (size_eff == 2'b10 && cpu.addr[1:0] != 2'b00);
`else
    // Without trapping, low bits are dropped so the lane is naturally aligned.
    r_in.trap = 1'b0;
    case (size_eff)
      2'b00:   r_in.off = cpu.addr[1:0];
      2'b01:   r_in.off = {cpu.addr[1], 1'b0};
      default: r_in.off = 2'b00;
    endcase
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: begin
        state_nxt = IDLE;
        if (accept) begin
          if (r_in.trap)                                 state_nxt = FIN;
          else if (r_in.is_store && r_in.size == 2'b10) state_nxt = WR;
          else                                           state_nxt = RD;
        end
      end
      RD:      state_nxt = CAP;
      CAP:     state_nxt = r_q.is_store ? WR : FIN;
      WR:      state_nxt = FIN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Big-endian lanes: byte 0 sits in the top byte of the word.
  always_comb begin
    case (r_q.off)
      2'b01:   lane_b = mem.read_data[23:16];
      2'b10:   lane_b = mem.read_data[15:8];
      2'b11:   lane_b = mem.read_data[7:0];
      default: lane_b = mem.read_data[31:24];
    endcase
    lane_h = r_q.off[1] ? mem.read_data[15:0] : mem.read_data[31:16];

    case (r_q.size)
      2'b00:   extended = {{24{lane_b[7] & ~r_q.is_unsigned}}, lane_b};
      2'b01:   extended = {{16{lane_h[15] & ~r_q.is_unsigned}}, lane_h};
      default: extended = mem.read_data;
    endcase

    merged = mem.read_data;
    if (r_q.size == 2'b00) begin
      case (r_q.off)
        2'b00: merged[31:24] = r_q.sdata[7:0];
        2'b01: merged[23:16] = r_q.sdata[7:0];
        2'b10: merged[15:8]  = r_q.sdata[7:0];
        2'b11: merged[7:0]   = r_q.sdata[7:0];
      endcase
    end else if (r_q.size == 2'b01) begin
      if (r_q.off[1]) merged[15:0]  = r_q.sdata;
      else            merged[31:16] = r_q.sdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q     <= '0;
      wdata_q <= '0;
      ldata_q <= '0;
    end else begin
      if (accept) begin
        r_q <= r_in;
        if (r_in.is_store && r_in.size == 2'b10 && !r_in.trap) wdata_q <= cpu.store_data;
      end
      if (state == CAP) begin
        if (r_q.is_store) wdata_q <= merged;
        else              ldata_q <= extended;
      end
    end
  end

  assign mem.MemRead    = (state == RD);
  assign mem.MemWrite   = (state == WR);
  assign mem.address    = (state == RD || state == WR) ? {r_q.waddr, 2'b00} : '0;
  assign mem.write_data = wdata_q;

  assign cpu.busy      = (state == RD) || (state == CAP) || (state == WR);
  assign cpu.done      = (state == FIN);
  assign cpu.error     = (state == FIN) && r_q.trap;
  assign cpu.load_data = ldata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-abort sequence, randomized ops vs byte-level model.
module tb_load_store_unit;
  localparam int AW = 11;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cpu_bus_if #(.ADDR_WIDTH(AW)) cpu();
  mem_bus_if #(.ADDR_WIDTH(AW)) mem();

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clock(clock),
    .reset(reset),
    .cpu  (cpu),
    .mem  (mem)
  );

  logic [31:0] mem_arr [512];
  logic [31:0] ref_mem [512];
  logic [31:0] last_ld;
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  always @(posedge clock) begin
    if (mem.MemRead) mem.read_data <= mem_arr[mem.address[AW-1:2]];
    if (mem.MemWrite) begin
      mem_arr[mem.address[AW-1:2]] = mem.write_data;
      wr_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && (mem.MemRead || mem.MemWrite)) begin
      chk("strobe_exclusive", {31'b0, mem.MemRead & mem.MemWrite}, 32'd0);
      chk("addr_word_aligned", {30'b0, mem.address[1:0]}, 32'd0);
    end
  end

  // Reference: memory as bytes, lanes picked by byte offset, extension by arithmetic.
  task automatic model_op(input logic st, input logic [1:0] size, input logic uns,
                          input logic [AW-1:0] a, input logic [31:0] sd,
                          output int e_done, output int e_rdc, output int e_wrc,
                          output int e_word, output logic [31:0] e_wd, output logic e_err);
    int nb, k, aa;
    bit trap;
    logic [7:0] b [4];
    logic [31:0] w, v;
    nb     = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    aa     = int'(a);
    trap   = TRAP && ((aa % nb) != 0);
    e_word = aa / 4;
    e_wd   = '0;
    e_err  = trap;
    e_rdc  = 0;
    e_wrc  = 0;
    e_done = 1;
    if (trap) return;
    aa = aa - aa % nb;
    k  = aa % 4;
    w  = ref_mem[e_word];
    for (int i = 0; i < 4; i++) b[i] = w[31-8*i -: 8];
    if (!st) begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v = (v << 8) | 32'(b[k+i]);
      if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      last_ld = v;
      e_done  = 3;
      e_rdc   = 1;
    end else begin
      for (int i = 0; i < nb; i++) b[k+i] = 8'(sd >> (8*(nb-1-i)));
      w = {b[0], b[1], b[2], b[3]};
      ref_mem[e_word] = w;
      e_wd   = w;
      e_done = (nb == 4) ? 2 : 4;
      e_rdc  = (nb == 4) ? 0 : 1;
      e_wrc  = (nb == 4) ? 1 : 3;
    end
  endtask

  // Drives one request (gap idle cycles first) and records what the bus did until done.
  task automatic run_op(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [AW-1:0] a, input logic [31:0] sd, input int gap, input bit noise,
                        output int done_c, output int rd_c, output int wr_c, output int n_wr,
                        output logic [AW-1:0] op_addr, output logic [31:0] wd,
                        output logic err, output logic [31:0] ld);
    done_c = 0; rd_c = 0; wr_c = 0; n_wr = 0;
    op_addr = '0; wd = '0; err = 1'b0; ld = '0;
    repeat (gap) @(negedge clock);
    cpu.req = 1'b1; cpu.is_store = st; cpu.size = sz; cpu.is_unsigned = uns;
    cpu.addr = a; cpu.store_data = sd;
    @(posedge clock);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      cpu.req = 1'b0;
      if (mem.MemRead && rd_c == 0) begin rd_c = c; op_addr = mem.address; end
      if (mem.MemWrite) begin
        if (wr_c == 0) wr_c = c;
        n_wr++;
        op_addr = mem.address;
        wd = mem.write_data;
      end
      if (cpu.done) begin
        done_c = c; err = cpu.error; ld = cpu.load_data;
        break;
      end
      if (noise && cpu.busy) begin
        cpu.req = 1'b1; cpu.is_store = 1'b1; cpu.size = 2'b10;
        cpu.addr = AW'($urandom_range(0, 511) * 4); cpu.store_data = $urandom;
      end
    end
    cpu.req = 1'b0;
  endtask

  task automatic do_and_check(input string tag, input logic st, input logic [1:0] sz, input logic uns,
                              input logic [AW-1:0] a, input logic [31:0] sd, input int gap, input bit noise);
    int e_done, e_rdc, e_wrc, e_word, done_c, rd_c, wr_c, n_wr;
    logic [31:0] e_wd, wd, ld;
    logic e_err, err;
    logic [AW-1:0] op_addr;
    model_op(st, sz, uns, a, sd, e_done, e_rdc, e_wrc, e_word, e_wd, e_err);
    run_op(st, sz, uns, a, sd, gap, noise, done_c, rd_c, wr_c, n_wr, op_addr, wd, err, ld);
    chk({tag, "_done_cycle"}, 32'(done_c), 32'(e_done));
    chk({tag, "_read_cycle"}, 32'(rd_c), 32'(e_rdc));
    chk({tag, "_write_cycle"}, 32'(wr_c), 32'(e_wrc));
    chk({tag, "_write_count"}, 32'(n_wr), (e_wrc != 0) ? 32'd1 : 32'd0);
    if (e_rdc != 0 || e_wrc != 0) chk({tag, "_address"}, 32'(op_addr), 32'(e_word * 4));
    if (e_wrc != 0) chk({tag, "_write_data"}, wd, e_wd);
    chk({tag, "_error"}, {31'b0, err}, {31'b0, e_err});
    chk({tag, "_load_data"}, ld, last_ld);
    chk({tag, "_mem_word"}, mem_arr[e_word], ref_mem[e_word]);
  endtask

  typedef struct {
    logic st; logic [1:0] sz; logic uns; logic [AW-1:0] a; logic [31:0] sd; int gap;
    int e_done; int e_rdc; int e_wrc; logic [AW-1:0] e_addr; logic [31:0] e_wd;
    logic e_err; logic [31:0] e_ld; logic chk_ld;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic [1:0] sz, input logic uns, input int a,
                              input logic [31:0] sd, input int gap, input int e_done, input int e_rdc,
                              input int e_wrc, input int e_addr, input logic [31:0] e_wd,
                              input logic e_err, input logic [31:0] e_ld, input logic chk_ld);
    vec_t v;
    v.st = st; v.sz = sz; v.uns = uns; v.a = AW'(a); v.sd = sd; v.gap = gap;
    v.e_done = e_done; v.e_rdc = e_rdc; v.e_wrc = e_wrc; v.e_addr = AW'(e_addr);
    v.e_wd = e_wd; v.e_err = e_err; v.e_ld = e_ld; v.chk_ld = chk_ld;
    return v;
  endfunction

  initial begin
    vec_t vq[$];
    int d0, d1, d2, d3, n0;
    logic [31:0] w0;
    logic e0;
    int done_c, rd_c, wr_c, n_wr;
    logic [AW-1:0] op_addr;
    logic [31:0] wd, ld;
    logic err;

    cpu.req = 1'b0; cpu.is_store = 1'b0; cpu.size = 2'b00; cpu.is_unsigned = 1'b0;
    cpu.addr = '0; cpu.store_data = '0;
    for (int i = 0; i < 512; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[4] = 32'h8899AABB;
    ref_mem[4] = 32'h8899AABB;
    last_ld = '0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_busy", {31'b0, cpu.busy}, 32'd0);
    chk("reset_done", {31'b0, cpu.done}, 32'd0);
    chk("reset_error", {31'b0, cpu.error}, 32'd0);
    chk("reset_memread", {31'b0, mem.MemRead}, 32'd0);
    chk("reset_memwrite", {31'b0, mem.MemWrite}, 32'd0);
    chk("reset_address", 32'(mem.address), 32'd0);
    chk("reset_write_data", mem.write_data, 32'd0);
    chk("reset_load_data", cpu.load_data, 32'd0);
    reset = 1'b0;

    //          st sz uns addr    sdata         gap done         rdc          wrc addr    wdata         err   load_data
    vq.push_back(mk(0, 0, 0, 'h012, 0,            1, 3,           1,           0, 'h010, 0,            0,    'hFFFFFFAA, 1));
    vq.push_back(mk(0, 1, 1, 'h012, 0,            1, 3,           1,           0, 'h010, 0,            0,    'h0000AABB, 1));
    vq.push_back(mk(0, 1, 0, 'h010, 0,            1, 3,           1,           0, 'h010, 0,            0,    'hFFFF8899, 1));
    vq.push_back(mk(0, 0, 1, 'h013, 0,            1, 3,           1,           0, 'h010, 0,            0,    'h000000BB, 1));
    vq.push_back(mk(0, 0, 0, 'h011, 0,            1, 3,           1,           0, 'h010, 0,            0,    'hFFFFFF99, 1));
    vq.push_back(mk(0, 2, 0, 'h010, 0,            1, 3,           1,           0, 'h010, 0,            0,    'h8899AABB, 1));
    vq.push_back(mk(0, 2, 0, 'h013, 0,            1, TRAP ? 1 : 3, TRAP ? 0 : 1, 0, 'h010, 0,         TRAP, 'h8899AABB, 1));
    vq.push_back(mk(0, 1, 1, 'h011, 0,            1, TRAP ? 1 : 3, TRAP ? 0 : 1, 0, 'h010, 0,         TRAP,
                    TRAP ? 32'h8899AABB : 32'h00008899, 1));
    vq.push_back(mk(0, 3, 0, 'h010, 0,            1, 3,           1,           0, 'h010, 0,            0,    'h8899AABB, 1));
    vq.push_back(mk(1, 0, 0, 'h011, 'h0000005C,   1, 4,           1,           3, 'h010, 'h885CAABB,   0,    0,          0));
    vq.push_back(mk(0, 2, 0, 'h010, 0,            1, 3,           1,           0, 'h010, 0,            0,    'h885CAABB, 1));
    vq.push_back(mk(1, 1, 0, 'h012, 'hFFFF1234,   1, 4,           1,           3, 'h010, 'h885C1234,   0,    0,          0));
    vq.push_back(mk(0, 1, 0, 'h012, 0,            1, 3,           1,           0, 'h010, 0,            0,    'h00001234, 1));
    vq.push_back(mk(1, 2, 0, 'h020, 'h12345678,   1, 2,           0,           1, 'h020, 'h12345678,   0,    0,          0));
    vq.push_back(mk(0, 2, 0, 'h020, 0,            0, 3,           1,           0, 'h020, 0,            0,    'h12345678, 1));
    vq.push_back(mk(0, 0, 0, 'h023, 0,            1, 3,           1,           0, 'h020, 0,            0,    'h00000078, 1));
    vq.push_back(mk(1, 2, 0, 'h010, 'h8899AABB,   1, 2,           0,           1, 'h010, 'h8899AABB,   0,    0,          0));

    foreach (vq[i]) begin
      model_op(vq[i].st, vq[i].sz, vq[i].uns, vq[i].a, vq[i].sd, d0, d1, d2, d3, w0, e0);
      if (vq[i].gap == 0) chk($sformatf("v%0d_req_in_fin", i), {31'b0, cpu.done}, 32'd1);
      run_op(vq[i].st, vq[i].sz, vq[i].uns, vq[i].a, vq[i].sd, vq[i].gap, 1'b0,
             done_c, rd_c, wr_c, n_wr, op_addr, wd, err, ld);
      chk($sformatf("v%0d_done_cycle", i), 32'(done_c), 32'(vq[i].e_done));
      chk($sformatf("v%0d_read_cycle", i), 32'(rd_c), 32'(vq[i].e_rdc));
      chk($sformatf("v%0d_write_cycle", i), 32'(wr_c), 32'(vq[i].e_wrc));
      chk($sformatf("v%0d_write_count", i), 32'(n_wr), (vq[i].e_wrc != 0) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_error", i), {31'b0, err}, {31'b0, vq[i].e_err});
      if (vq[i].e_rdc != 0 || vq[i].e_wrc != 0)
        chk($sformatf("v%0d_address", i), 32'(op_addr), 32'(vq[i].e_addr));
      if (vq[i].e_wrc != 0) begin
        chk($sformatf("v%0d_write_data", i), wd, vq[i].e_wd);
        chk($sformatf("v%0d_mem_word", i), mem_arr[vq[i].a[AW-1:2]], vq[i].e_wd);
      end
      if (vq[i].chk_ld) chk($sformatf("v%0d_load_data", i), ld, vq[i].e_ld);
    end

    // Half store aborted by reset while in the capture cycle.
    @(negedge clock);
    cpu.req = 1'b1; cpu.is_store = 1'b1; cpu.size = 2'b01; cpu.is_unsigned = 1'b0;
    cpu.addr = AW'(16); cpu.store_data = 32'h0000BEEF;
    @(posedge clock);
    @(negedge clock);
    cpu.req = 1'b0;
    chk("abort_read_cycle1", {31'b0, mem.MemRead}, 32'd1);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, cpu.busy}, 32'd0);
    chk("abort_done", {31'b0, cpu.done}, 32'd0);
    chk("abort_error", {31'b0, cpu.error}, 32'd0);
    chk("abort_memread", {31'b0, mem.MemRead}, 32'd0);
    chk("abort_memwrite", {31'b0, mem.MemWrite}, 32'd0);
    chk("abort_address", 32'(mem.address), 32'd0);
    chk("abort_write_data", mem.write_data, 32'd0);
    chk("abort_load_data", cpu.load_data, 32'd0);
    n0 = wr_cnt;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    last_ld = '0;
    chk("abort_no_write", 32'(wr_cnt), 32'(n0));
    chk("abort_mem_intact", mem_arr[4], 32'h8899AABB);
    do_and_check("post_reset_lw", 1'b0, 2'b10, 1'b0, AW'(16), 32'd0, 1, 1'b0);
    do_and_check("post_reset_sh", 1'b1, 2'b01, 1'b0, AW'(16), 32'h0000BEEF, 1, 1'b0);
    do_and_check("post_reset_lh", 1'b0, 2'b01, 1'b0, AW'(16), 32'd0, 1, 1'b0);

    for (int n = 0; n < 200; n++) begin
      do_and_check($sformatf("rnd%0d", n), 1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2),
                   AW'($urandom_range(0, 127)), $urandom, int'($urandom % 3), 1'($urandom % 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
